// File: rtl/io_pkg.sv
// Shared definitions for the IO store path: region codes, decoder address
// bounds, the default-width queue entry layout and the region priority rule.
package io_pkg;

   localparam logic [1:0] REG_NONE = 2'b00;
   localparam logic [1:0] REG_SHOW = 2'b01;
   localparam logic [1:0] REG_ORIG = 2'b10;
   localparam logic [1:0] REG_PROC = 2'b11;

   // Address bounds used by the upstream IO address decoder
   localparam int unsigned BOUND_MEM_HI  = 96;
   localparam int unsigned BOUND_SHOW    = 100;
   localparam int unsigned BOUND_ORIG_LO = 120;
   localparam int unsigned BOUND_PROC_LO = 130;
   localparam int unsigned BOUND_PROC_HI = 140;

   localparam int unsigned IO_ADDR_W = 24;
   localparam int unsigned IO_DATA_W = 32;

   typedef struct packed {
      logic [1:0]           region;
      logic [IO_ADDR_W-1:0] addr;
      logic [IO_DATA_W-1:0] data;
   } io_entry_t;

   // Overlapping decoder enables resolve as process > original > show
   function automatic logic [1:0] encode_region(input logic show_enb,
                                                input logic original_enb,
                                                input logic process_enb);
      if (process_enb)
         return REG_PROC;
      else if (original_enb)
         return REG_ORIG;
      else if (show_enb)
         return REG_SHOW;
      else
         return REG_NONE;
   endfunction

endpackage

// File: rtl/io_region_enc.sv
// Priority encoder from the IO decoder enables to a region code, plus the
// qualified IO-store strobe.
module io_region_enc
   import io_pkg::*;
(
   input  logic       we,
   input  logic       show_enb,
   input  logic       original_enb,
   input  logic       process_enb,
   output logic       io_store,
   output logic [1:0] region
);

   // Resolve the region and flag stores that target an IO region
   always_comb begin
      region   = encode_region(show_enb, original_enb, process_enb);
      io_store = we & (region != REG_NONE);
   end

endmodule

// File: rtl/io_store_queue.sv
// FIFO of CPU stores that hit an IO region, drained to the display/image
// writer over valid/ready. Stalls the CPU when a store cannot be accepted.
module io_store_queue
   import io_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          address,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       show_enb,
   input  logic                       original_enb,
   input  logic                       process_enb,
   input  logic                       flush,
   output logic                       stall,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [1:0]                 out_region,
   output logic [ADDR_W-1:0]          out_addr,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [1:0]        region;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } q_entry_t;

   q_entry_t        mem [DEPTH];
   q_entry_t        head;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            io_store;
   logic [1:0]      region;
   logic            full;
   logic            push;
   logic            pop;

   io_region_enc u_enc (
      .we           (we),
      .show_enb     (show_enb),
      .original_enb (original_enb),
      .process_enb  (process_enb),
      .io_store     (io_store),
      .region       (region)
   );

   // Handshake decode; a pop while full frees the slot the push lands in
   always_comb begin
      full  = (count == FULL);
      pop   = out_valid & out_ready;
      push  = io_store & ~flush & (~full | pop);
      stall = io_store & full & ~pop & ~flush;
   end

   // Entry storage; zeroed on reset, left untouched by flush
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= '{region: region, addr: address, data: wdata};
      end
   end

   // Pointer and occupancy tracking; reset and flush both empty the queue
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Head entry presented straight from storage
   always_comb begin
      head       = mem[rd_ptr];
      out_valid  = (count != '0);
      out_region = head.region;
      out_addr   = head.addr;
      out_data   = head.data;
   end

endmodule

// File: doc/io_store_queue.md
Name: io_store_queue

Overview:
- Downstream consumer of the IO address decoder's enables in the single-cycle processor.
- Captures CPU stores that hit an IO region (show, original or process) into a small FIFO.
- Drains entries to the display/image writer over a valid/ready handshake.
- Asserts stall to the CPU when a store cannot be accepted.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- ADDR_W, 24, address width; matches the decoder input.
- DATA_W, 32, store data width.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- we, input, 1, CPU store strobe for the current instruction.
- address, input, ADDR_W, CPU store address.
- wdata, input, DATA_W, CPU store data.
- show_enb, input, 1, decoder enable: address > 100.
- original_enb, input, 1, decoder enable: 120 <= address < 130.
- process_enb, input, 1, decoder enable: 130 <= address <= 140.
- flush, input, 1, synchronous clear of all queued entries.
- stall, output, 1, combinational; CPU must hold the store instruction while high.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, consumer accepts the head entry.
- out_region, output, 2, head region: 01 show, 10 original, 11 process.
- out_addr, output, ADDR_W, head store address (unmodified).
- out_data, output, DATA_W, head store data.
- count, output, log2(DEPTH)+1, number of occupied entries.

Behaviour:
- Region encode (combinational), priority process > original > show.
  - process_enb gives 11; else original_enb gives 10; else show_enb gives 01; else 00.
  - io_store = we & (region != 00).
- pop = out_valid & out_ready.
- push = io_store & (count < DEPTH | pop).
  - When full, a same-cycle pop frees a slot and the push is accepted.
- stall = io_store & (count == DEPTH) & !pop. Purely combinational, no registered delay.
- Write and advance:
  - On push, write {region, address, wdata} at the write pointer and advance it.
  - On pop, advance the read pointer.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count update:
  - +1 on push only; -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds DEPTH and never goes below 0.
- Output timing:
  - out_valid = (count != 0), registered via count.
  - Latency from push on an empty queue to out_valid high: 1 cycle.
  - No combinational bypass from input to output.
- Head fields:
  - out_region, out_addr and out_data read the entry at the read pointer.
  - They must hold stable while out_valid & !out_ready.
- Reset (rst=1) takes priority over everything. On the next edge:
  - Pointers = 0, count = 0, all storage entries = 0.
  - Hence out_valid = 0, out_region = 00, out_addr = 0, out_data = 0.
  - stall follows its equation.
  - Reset mid-transfer discards all entries with no partial pop.
- flush, when not in reset:
  - Same clearing as reset, except storage contents are not zeroed.
  - A push in the same cycle as flush is dropped.
  - stall is forced to 0 during flush.
- Non-IO stores: we with region 00 (mem region or unmapped addresses 97..100) never pushes and never stalls.
- Loads (we=0) are ignored.

Decomposition:
- Package io_pkg:
  - Region codes REG_NONE=00, REG_SHOW=01, REG_ORIG=10, REG_PROC=11.
  - Region bound constants 96, 100, 120, 130, 140.
  - Packed struct io_entry_t {region, addr, data}.
- One sub-module, io_region_enc: combinational priority encoder from the three enables plus we to {io_store, region}.
- FIFO storage and pointers stay in io_store_queue.

Test Plan:
- Single store:
  - Stimulus: reset, then we=1, address=125, original_enb=1, show_enb=1, wdata=0xDEADBEEF for 1 cycle.
  - Response: next cycle out_valid=1, out_region=10, out_addr=125, out_data=0xDEADBEEF, count=1.
  - With out_ready=1, count returns to 0 one cycle later.
- Fill and stall:
  - Stimulus: out_ready=0, 9 consecutive stores to address 135 (process_enb=1, show_enb=1) with data 1..9.
  - Response: count reaches 8; stall=1 on the 9th store and the entry is not written.
  - Raising out_ready pops data 1 and accepts data 9 in the same cycle, stall drops, count stays 8.
- Order and wrap:
  - Stimulus: push 20 stores with data 0..19 while randomly toggling out_ready.
  - Response: output sequence is exactly 0..19, pointers wrap, and out_* are stable whenever valid & !ready.
- Non-IO stores:
  - Stimulus: we=1, address=50 (mem) and address=98 (no enable) while the queue is full.
  - Response: stall=0 and count unchanged.
- Reset/flush mid-operation:
  - Stimulus: with count=5, assert rst for 1 cycle.
  - Response: next cycle count=0, out_valid=0, out_data=0.
  - Repeat with flush plus a simultaneous store: count=0 and the store is dropped.
